// File: rtl/load_reader.sv
// ---------------------------------------------------------------------------
// load_reader
//
// Read-side companion to the multi-cycle datapath's memory-data holding
// register. It accepts a load request from the control unit and issues a
// word read to data memory over a req/ack handshake. From the returned word
// it extracts the addressed byte, halfword or word, sign- or zero-extends
// that value, and holds the result for the write-back step. It also flags
// misaligned accesses, reserved load codes and (optionally) unanswered reads.
//
// Parameters:
//   N        data/address width (only 32 is supported)
//   TIMEOUT  max cycles to wait for mem_ack in REQ (1..255)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      load request, sampled only while idle
//   addr       byte address of the load
//   funct      load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   mem_req    read request to data memory (high for all of REQ)
//   mem_addr   word-aligned read address
//   mem_ack    read-data-valid strobe from memory
//   mem_rdata  read data, valid with mem_ack
//   data_out   extended load result, held between loads
//   busy       high whenever not idle
//   done       one-cycle completion pulse
//   err        sticky error flag for the most recent load
//
// Optional feature macro: LOAD_READER_TIMEOUT_EN
//   When defined, a REQ wait counter aborts the read with err=1 after
//   TIMEOUT cycles without mem_ack. When undefined, REQ waits forever and
//   TIMEOUT is only range-checked.
// ---------------------------------------------------------------------------
module load_reader #(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] addr,
  input  logic [2:0]   funct,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] data_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("load_reader: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, next_state;

  // Transaction context captured when a request is accepted.
  logic [2:0]  funct_q;
  logic [1:0]  off_q;

  logic        legal_funct;
  logic        misaligned;
  logic        accept;
  logic        reject;
  logic        capture;
  logic        timeout_hit;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        ext_bit;
  logic [N-1:0] extracted;

  // Request decode: a load is legal when funct is one of the five defined
  // codes and the address is naturally aligned for the access size.
  always_comb begin
    legal_funct = 1'b0;
    misaligned  = 1'b0;
    case (funct)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_funct = 1'b1;
      default:                                legal_funct = 1'b0;
    endcase
    case (funct[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Big-endian lane select: offset 0 is the most significant byte, so the
  // halfword at offset 0 is the upper half of the word.
  always_comb begin
    sel_byte = 8'h00;
    case (off_q)
      2'd0:    sel_byte = mem_rdata[31:24];
      2'd1:    sel_byte = mem_rdata[23:16];
      2'd2:    sel_byte = mem_rdata[15:8];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  // funct[2] marks the unsigned variants; funct[1:0] selects the size.
  always_comb begin
    ext_bit   = 1'b0;
    extracted = mem_rdata;
    case (funct_q[1:0])
      2'b00: begin
        ext_bit   = ~funct_q[2] & sel_byte[7];
        extracted = {{24{ext_bit}}, sel_byte};
      end
      2'b01: begin
        ext_bit   = ~funct_q[2] & sel_half[15];
        extracted = {{16{ext_bit}}, sel_half};
      end
      default: extracted = mem_rdata;
    endcase
  end

`ifdef LOAD_READER_TIMEOUT_EN
  logic [7:0] count_q;

  // Counts REQ cycles without an ack; fires on the cycle the count would
  // reach TIMEOUT so mem_req is high for exactly TIMEOUT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else if (accept) begin
      count_q <= 8'd0;
    end else if (state == REQ && !mem_ack) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign timeout_hit = (state == REQ) && !mem_ack &&
                       ((count_q + 8'd1) == 8'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. mem_req/busy/done come straight from
  // the state so an asynchronous reset drops them without a clock edge.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    capture    = 1'b0;
    mem_req    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (legal_funct && !misaligned) begin
            accept     = 1'b1;
            next_state = REQ;
          end else begin
            reject     = 1'b1;
            next_state = FIN;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture    = 1'b1;
          next_state = FIN;
        end else if (timeout_hit) begin
          next_state = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath registers. data_out only moves on an ack capture; err is
  // cleared on acceptance and set on any rejected or timed-out load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
      funct_q  <= 3'b000;
      off_q    <= 2'b00;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr <= {addr[N-1:2], 2'b00};
        funct_q  <= funct;
        off_q    <= addr[1:0];
        err      <= 1'b0;
      end
      if (reject || timeout_hit) begin
        err <= 1'b1;
      end
      if (capture) begin
        data_out <= extracted;
      end
    end
  end

endmodule
